// File: rtl/fma_pipe.sv
// rtl/fma_pipe.sv - three-stage stall-all single-precision multiply-add (fmul then fadd)
package fma_pipe_pkg;
  localparam logic [31:0] QNAN = 32'h7FC00000;

  // Round and pack: sig[26] is the hidden bit, sig[2] guard, sig[1:0] sticky.
  function automatic logic [31:0] round_pack(input logic s, input logic signed [11:0] e,
                                             input logic [26:0] sig, input logic [2:0] rm);
    logic [26:0] m;
    logic signed [11:0] ee;
    logic [24:0] r;
    logic inc, g, st, lsb;
    int sh;
    m  = sig;
    ee = e;
    if (ee < 12'sd1) begin
      sh = 1 - int'(ee);
      if (sh > 26) m = {26'd0, |sig};
      else m = (sig >> sh) | {26'd0, |(sig & ((27'd1 << sh) - 27'd1))};
      ee = 12'sd1;
    end
    lsb = m[3];
    g   = m[2];
    st  = |m[1:0];
    case (rm)
      3'b001:  inc = 1'b0;
      3'b010:  inc = s & (g | st);
      3'b011:  inc = ~s & (g | st);
      3'b100:  inc = g;
      default: inc = g & (st | lsb);
    endcase
    r = {1'b0, m[26:3]} + {24'd0, inc};
    if (r[24]) begin
      r  = r >> 1;
      ee = ee + 12'sd1;
    end
    if (ee > 12'sd254) begin
      if (rm == 3'b001 || (rm == 3'b010 && !s) || (rm == 3'b011 && s))
        return {s, 8'hFE, 23'h7FFFFF};
      return {s, 8'hFF, 23'd0};
    end
    return {s, (r[23] ? ee[7:0] : 8'd0), r[22:0]};
  endfunction
endpackage

module fma_fmul
  import fma_pipe_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [2:0]  rm_i,
  output logic [31:0] res_o
);
  logic        sa, sb, sp;
  logic [7:0]  ea, eb, ea1, eb1;
  logic [22:0] fa, fb;
  logic [47:0] p, pn;
  logic [5:0]  lzc;
  logic signed [11:0] e;
  logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;

  always_comb begin
    {sa, ea, fa} = a_i;
    {sb, eb, fb} = b_i;
    sp     = sa ^ sb;
    a_nan  = (ea == 8'hFF) && (fa != 23'd0);
    b_nan  = (eb == 8'hFF) && (fb != 23'd0);
    a_inf  = (ea == 8'hFF) && (fa == 23'd0);
    b_inf  = (eb == 8'hFF) && (fb == 23'd0);
    a_zero = (ea == 8'd0) && (fa == 23'd0);
    b_zero = (eb == 8'd0) && (fb == 23'd0);
    ea1    = (ea == 8'd0) ? 8'd1 : ea;
    eb1    = (eb == 8'd0) ? 8'd1 : eb;
    p      = 48'({|ea, fa}) * 48'({|eb, fb});
    lzc    = '0;
    for (int i = 0; i < 48; i++) if (p[i]) lzc = 6'(47 - i);
    pn     = p << lzc;
    // Product binary point sits after bit 46; normalising to bit 47 costs one exponent step.
    e      = $signed({4'd0, ea1}) + $signed({4'd0, eb1}) - 12'sd126 - $signed({6'd0, lzc});
    res_o  = round_pack(sp, e, {pn[47:22], |pn[21:0]}, rm_i);
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) res_o = QNAN;
    else if (a_inf || b_inf) res_o = {sp, 8'hFF, 23'd0};
    else if (a_zero || b_zero) res_o = {sp, 31'd0};
  end
endmodule

module fma_fadd
  import fma_pipe_pkg::*;
(
  input  logic [31:0] x_i,
  input  logic [31:0] y_i,
  input  logic [2:0]  rm_i,
  output logic [31:0] res_o
);
  logic        sx, sy, sb, ss, swap;
  logic [7:0]  ex, ey, ex1, ey1, eb, es, d;
  logic [22:0] fx, fy;
  logic [23:0] mx, my, mb, ms;
  logic [26:0] mb27, ms27, al, diff, sig;
  logic [27:0] sum;
  logic [4:0]  lz;
  logic signed [11:0] e;
  logic x_nan, y_nan, x_inf, y_inf;

  always_comb begin
    {sx, ex, fx} = x_i;
    {sy, ey, fy} = y_i;
    x_nan = (ex == 8'hFF) && (fx != 23'd0);
    y_nan = (ey == 8'hFF) && (fy != 23'd0);
    x_inf = (ex == 8'hFF) && (fx == 23'd0);
    y_inf = (ey == 8'hFF) && (fy == 23'd0);
    ex1   = (ex == 8'd0) ? 8'd1 : ex;
    ey1   = (ey == 8'd0) ? 8'd1 : ey;
    mx    = {|ex, fx};
    my    = {|ey, fy};
    swap  = {ex1, mx} < {ey1, my};
    sb    = swap ? sy : sx;
    ss    = swap ? sx : sy;
    eb    = swap ? ey1 : ex1;
    es    = swap ? ex1 : ey1;
    mb    = swap ? my : mx;
    ms    = swap ? mx : my;
    d     = eb - es;
    mb27  = {mb, 3'b000};
    ms27  = {ms, 3'b000};
    if (d > 8'd26) al = {26'd0, |ms27};
    else al = (ms27 >> d) | {26'd0, |(ms27 & ((27'd1 << d) - 27'd1))};
    sum   = {1'b0, mb27} + {1'b0, al};
    diff  = mb27 - al;
    lz    = '0;
    for (int i = 0; i < 27; i++) if (diff[i]) lz = 5'(26 - i);
    if (sb == ss) begin
      if (sum[27]) begin
        sig = {sum[27:2], |sum[1:0]};
        e   = $signed({4'd0, eb}) + 12'sd1;
      end else begin
        sig = sum[26:0];
        e   = $signed({4'd0, eb});
      end
      res_o = round_pack(sb, e, sig, rm_i);
    end else begin
      sig   = diff << lz;
      e     = $signed({4'd0, eb}) - $signed({7'd0, lz});
      res_o = round_pack(sb, e, sig, rm_i);
      // Exact cancellation yields +0 except when rounding toward -inf.
      if (diff == 27'd0) res_o = {(rm_i == 3'b010), 31'd0};
    end
    if (x_nan || y_nan || (x_inf && y_inf && (sx != sy))) res_o = QNAN;
    else if (x_inf) res_o = x_i;
    else if (y_inf) res_o = y_i;
  end
endmodule

module fma_pipe #(
  parameter int TAG_W       = 4,
  parameter int DEPTH_CNT_W = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            in_a,
  input  logic [31:0]            in_b,
  input  logic [31:0]            in_c,
  input  logic [1:0]             in_op,
  input  logic [2:0]             in_rm,
  input  logic [TAG_W-1:0]       in_tag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_res,
  output logic [TAG_W-1:0]       out_tag,
  output logic [DEPTH_CNT_W-1:0] in_flight
);
  logic             adv;
  logic             s1_valid_q, s2_valid_q, s3_valid_q;
  logic [31:0]      s1_a_q, s1_b_q, s1_c_q, s2_p_q, s2_c_q, s3_res_q;
  logic [1:0]       s1_op_q, s2_op_q;
  logic [2:0]       s1_rm_q, s2_rm_q;
  logic [TAG_W-1:0] s1_tag_q, s2_tag_q, s3_tag_q;
  logic [31:0]      p_d, add_x_d, add_y_d, sum_d;

  assign adv      = ~s3_valid_q | out_ready;
  assign in_ready = adv;

  fma_fmul u_fmul (.a_i(s1_a_q), .b_i(s1_b_q), .rm_i(s1_rm_q), .res_o(p_d));

  // Sign selection is a raw bit-31 flip, so NaN signs flip as well.
  assign add_x_d = {s2_p_q[31] ^ s2_op_q[1], s2_p_q[30:0]};
  assign add_y_d = {s2_c_q[31] ^ s2_op_q[0], s2_c_q[30:0]};

  fma_fadd u_fadd (.x_i(add_x_d), .y_i(add_y_d), .rm_i(s2_rm_q), .res_o(sum_d));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s3_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_c_q     <= '0;
      s1_op_q    <= '0;
      s1_rm_q    <= '0;
      s1_tag_q   <= '0;
      s2_p_q     <= '0;
      s2_c_q     <= '0;
      s2_op_q    <= '0;
      s2_rm_q    <= '0;
      s2_tag_q   <= '0;
      s3_res_q   <= '0;
      s3_tag_q   <= '0;
    end else if (adv) begin
      s1_valid_q <= in_valid;
      s1_a_q     <= in_a;
      s1_b_q     <= in_b;
      s1_c_q     <= in_c;
      s1_op_q    <= in_op;
      s1_rm_q    <= in_rm;
      s1_tag_q   <= in_tag;
      s2_valid_q <= s1_valid_q;
      s2_p_q     <= p_d;
      s2_c_q     <= s1_c_q;
      s2_op_q    <= s1_op_q;
      s2_rm_q    <= s1_rm_q;
      s2_tag_q   <= s1_tag_q;
      s3_valid_q <= s2_valid_q;
      s3_res_q   <= sum_d;
      s3_tag_q   <= s2_tag_q;
    end
  end

  assign out_valid = s3_valid_q;
  assign out_res   = s3_res_q;
  assign out_tag   = s3_tag_q;
  assign in_flight = DEPTH_CNT_W'(s1_valid_q) + DEPTH_CNT_W'(s2_valid_q)
                   + DEPTH_CNT_W'(s3_valid_q);
endmodule

// File: doc/fma_pipe.md
Name: fma_pipe

Overview:
- Pipelined single-precision multiply-add unit for the FPU datapath, built from the existing combinational fmul and fadd blocks.
- Implements all four fused-op modes: fmadd, fmsub, fnmsub and fnmadd.
- Uses a valid/ready handshake on both sides, stalls globally under backpressure, and carries a user tag for out-of-order bookkeeping upstream.
- Not IEEE-fused: the product is rounded (by fmul) before the add (by fadd), both with the op's rm.

Parameters:
- TAG_W, 4, width of the opaque tag carried alongside each op.
- DEPTH_CNT_W, 2, width of the in-flight occupancy counter; must hold the value 3.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand bundle valid.
- in_ready  output  1  unit can accept a bundle this cycle.
- in_a  input  32  multiplicand, IEEE-754 single.
- in_b  input  32  multiplier.
- in_c  input  32  addend.
- in_op  input  2  00 fmadd (a*b)+c; 01 fmsub (a*b)-c; 10 fnmsub -(a*b)+c; 11 fnmadd -(a*b)-c.
- in_rm  input  3  rounding mode, passed to fmul and fadd for this op.
- in_tag  input  TAG_W  opaque tag.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- out_res  output  32  result.
- out_tag  output  TAG_W  tag of the result.
- in_flight  output  DEPTH_CNT_W  number of valid stages, 0..3.

Behaviour:
- Three register stages.
  - S1: latches a, b, c, op, rm, tag.
  - S2: latches P = fmul(a, b, rm); carries c, op, rm, tag.
  - S3: latches the fadd result; drives out_*.
- Sign handling:
  - op[1]=1 inverts bit 31 of P before the add.
  - op[0]=1 inverts bit 31 of c before the add.
  - Pure bit-31 flips, so NaN signs flip too; this is accepted.
- Global advance: adv = ~s3_valid | out_ready. All stages shift when adv=1 and hold otherwise. in_ready = adv (combinational).
- Accept: in_valid & in_ready at edge N loads S1. Absent stalls, out_valid=1 after edge N+2, i.e. a 3-cycle latency. Throughput is 1 op/cycle.
- Bubbles: a stage with valid=0 propagates valid=0. Bubbles are never collapsed; the pipeline is a simple stall-all design.
- Output: out_valid = s3_valid. out_res and out_tag stay stable while out_valid & ~out_ready.
- in_flight = s1_valid + s2_valid + s3_valid, registered view.
- Simultaneous out handshake and in accept in one cycle: both occur, and in_flight is unchanged.
- in_valid=0 while adv=1: S1 loads a bubble.
- Reset (any time, including mid-operation):
  - All stage valids clear immediately, so out_valid=0, in_flight=0 and in_ready=1.
  - Data registers reset to 0, so out_res=0 and out_tag=0.
  - In-flight ops are discarded, not flushed out.
- No exception flags. Special values follow fmul/fadd behaviour unchanged.

Test Plan:
- Directed ops, one at a time with out_ready=1, using a=0x40000000 (2.0), b=0x40400000 (3.0), c=0x3F800000 (1.0), rm=000:
  - op 00 -> out_res=0x40E00000 (7.0).
  - op 01 -> 0x40A00000 (5.0).
  - op 10 -> 0xC0A00000 (-5.0).
  - op 11 -> 0xC0E00000 (-7.0).
  - Each out_valid appears exactly 3 cycles after acceptance.
- Streaming: 8 back-to-back ops with tags 0..7 and out_ready=1 -> results emerge in order on 8 consecutive cycles, with in_flight=3 at steady state.
- Backpressure: fill the pipe, then hold out_ready=0 for 5 cycles -> in_ready=0, out_res and out_tag frozen, in_flight=3. Release -> no loss and no duplication.
- Bubbles: alternate in_valid 1/0 -> out_valid alternates with the same pattern, and tags match.
- Reset mid-stream: assert rst with 3 ops in flight -> out_valid=0, in_flight=0, in_ready=1 asynchronously. After release, a new op completes with the correct value.
- Special operand: a=0x7F800000 (+inf), b=0x00000000, c=1.0, op 00 -> the same result as a standalone fmul followed by fadd (NaN).
